// File: rtl/checkers_move_engine.sv
// Checkers move engine: owns the live 8x8 board, validates and commits one move per request,
// then rescans piece counts to detect game over before reporting a result code.
module checkers_move_engine #(
    parameter logic [191:0] INIT_BOARD   = 192'o02020202_20202020_02020202_70707070_07070707_10101010_01010101_10101010,
    parameter logic         FIRST_PLAYER = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         new_game,
    input  logic         move_valid,
    output logic         move_ready,
    input  logic [3:0]   from_x,
    input  logic [3:0]   from_y,
    input  logic [3:0]   to_x,
    input  logic [3:0]   to_y,
    output logic         result_valid,
    output logic [2:0]   result_code,
    output logic [191:0] board_out,
    output logic         turn,
    output logic         game_over,
    output logic         winner,
    output logic [4:0]   p1_count,
    output logic [4:0]   p2_count
);

    localparam logic [2:0] CELL_EMPTY = 3'b111;
    localparam logic [2:0] P1_MAN     = 3'b001;
    localparam logic [2:0] P2_MAN     = 3'b010;
    localparam logic [2:0] P1_KING    = 3'b011;
    localparam logic [2:0] P2_KING    = 3'b100;

    localparam logic [2:0] OK_MOVE    = 3'd0;
    localparam logic [2:0] OK_CAPTURE = 3'd1;
    localparam logic [2:0] ERR_RANGE  = 3'd2;
    localparam logic [2:0] ERR_SRC    = 3'd3;
    localparam logic [2:0] ERR_DST    = 3'd4;
    localparam logic [2:0] ERR_GEOM   = 3'd5;
    localparam logic [2:0] ERR_OVER   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CHECK, S_COMMIT, S_SCAN, S_DONE
    } state_t;

    function automatic logic [5:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return (({2'b00, y} - 6'd1) * 6'd8) + ({2'b00, x} - 6'd1);
    endfunction

    // Cell 0 sits in the most significant triple of the board vector.
    function automatic logic [2:0] get_cell(input logic [191:0] b, input logic [5:0] idx);
        logic [7:0]   sh;
        logic [191:0] tmp;
        sh  = 8'd3 * {2'b00, 6'd63 - idx};
        tmp = b >> sh;
        return tmp[2:0];
    endfunction

    function automatic logic [191:0] set_cell(input logic [191:0] b, input logic [5:0] idx,
                                              input logic [2:0] v);
        logic [7:0] sh;
        sh = 8'd3 * {2'b00, 6'd63 - idx};
        return (b & ~({189'd0, 3'b111} << sh)) | ({189'd0, v} << sh);
    endfunction

    function automatic logic in_range(input logic [3:0] v);
        return (v != 4'd0) && (v <= 4'd8);
    endfunction

    state_t        state_q, state_d;
    logic [191:0]  board_q, board_d;
    logic          turn_q, turn_d;
    logic          game_over_q, game_over_d;
    logic          winner_q, winner_d;
    logic [4:0]    p1_count_q, p1_count_d, p2_count_q, p2_count_d;
    logic [3:0]    fx_q, fx_d, fy_q, fy_d, tx_q, tx_d, ty_q, ty_d;
    logic [2:0]    src_q, src_d, dst_q, dst_d, mid_q, mid_d;
    logic [2:0]    code_q, code_d;
    logic [5:0]    scan_idx_q, scan_idx_d;
    logic [4:0]    acc1_q, acc1_d, acc2_q, acc2_d;
    logic          reset_scan_q, reset_scan_d;

    logic [4:0]        sum_x, sum_y;
    logic [3:0]        mid_x, mid_y;
    logic [5:0]        src_idx, dst_idx, mid_idx;
    logic signed [4:0] dx, dy, adx, ady;
    logic [2:0]        own_man, own_king, opp_man, opp_king, moved_code, scan_cell;
    logic              coords_ok, src_own, is_king, forward, step_ok, jump_ok;
    logic [4:0]        acc1_next, acc2_next;

    assign sum_x   = {1'b0, fx_q} + {1'b0, tx_q};
    assign sum_y   = {1'b0, fy_q} + {1'b0, ty_q};
    assign mid_x   = 4'(sum_x >> 1);
    assign mid_y   = 4'(sum_y >> 1);
    assign src_idx = cell_idx(fx_q, fy_q);
    assign dst_idx = cell_idx(tx_q, ty_q);
    assign mid_idx = cell_idx(mid_x, mid_y);

    assign dx  = $signed({1'b0, tx_q}) - $signed({1'b0, fx_q});
    assign dy  = $signed({1'b0, ty_q}) - $signed({1'b0, fy_q});
    assign adx = dx[4] ? -dx : dx;
    assign ady = dy[4] ? -dy : dy;

    assign own_man   = turn_q ? P2_MAN  : P1_MAN;
    assign own_king  = turn_q ? P2_KING : P1_KING;
    assign opp_man   = turn_q ? P1_MAN  : P2_MAN;
    assign opp_king  = turn_q ? P1_KING : P2_KING;
    assign coords_ok = in_range(fx_q) && in_range(fy_q) && in_range(tx_q) && in_range(ty_q);
    assign src_own   = (src_q == own_man) || (src_q == own_king);
    assign is_king   = (src_q == own_king);
    assign forward   = turn_q ? (dy > 5'sd0) : (dy < 5'sd0);
    assign step_ok   = (adx == 5'sd1) && (ady == 5'sd1) && (is_king || forward);
    assign jump_ok   = (adx == 5'sd2) && (ady == 5'sd2) && (is_king || forward) &&
                       ((mid_q == opp_man) || (mid_q == opp_king));

    assign moved_code = ((src_q == P1_MAN) && (ty_q == 4'd1)) ? P1_KING :
                        ((src_q == P2_MAN) && (ty_q == 4'd8)) ? P2_KING : src_q;

    assign scan_cell = get_cell(board_q, scan_idx_q);
    assign acc1_next = acc1_q + {4'd0, (scan_cell == P1_MAN) || (scan_cell == P1_KING)};
    assign acc2_next = acc2_q + {4'd0, (scan_cell == P2_MAN) || (scan_cell == P2_KING)};

    // Next-state logic; new_game is applied last so it overrides any operation in progress.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        turn_d       = turn_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        p1_count_d   = p1_count_q;
        p2_count_d   = p2_count_q;
        fx_d         = fx_q;
        fy_d         = fy_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        src_d        = src_q;
        dst_d        = dst_q;
        mid_d        = mid_q;
        code_d       = code_q;
        scan_idx_d   = scan_idx_q;
        acc1_d       = acc1_q;
        acc2_d       = acc2_q;
        reset_scan_d = reset_scan_q;

        case (state_q)
            S_IDLE: begin
                if (move_valid) begin
                    fx_d    = from_x;
                    fy_d    = from_y;
                    tx_d    = to_x;
                    ty_d    = to_y;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                src_d   = get_cell(board_q, src_idx);
                dst_d   = get_cell(board_q, dst_idx);
                mid_d   = get_cell(board_q, mid_idx);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (game_over_q)               code_d = ERR_OVER;
                else if (!coords_ok)           code_d = ERR_RANGE;
                else if (!src_own)             code_d = ERR_SRC;
                else if (dst_q != CELL_EMPTY)  code_d = ERR_DST;
                else if (step_ok)              code_d = OK_MOVE;
                else if (jump_ok)              code_d = OK_CAPTURE;
                else                           code_d = ERR_GEOM;
                state_d = ((code_d == OK_MOVE) || (code_d == OK_CAPTURE)) ? S_COMMIT : S_DONE;
            end
            S_COMMIT: begin
                board_d = set_cell(set_cell(board_q, src_idx, CELL_EMPTY), dst_idx, moved_code);
                if (code_q == OK_CAPTURE)
                    board_d = set_cell(board_d, mid_idx, CELL_EMPTY);
                turn_d       = ~turn_q;
                scan_idx_d   = 6'd0;
                acc1_d       = 5'd0;
                acc2_d       = 5'd0;
                reset_scan_d = 1'b0;
                state_d      = S_SCAN;
            end
            S_SCAN: begin
                acc1_d     = acc1_next;
                acc2_d     = acc2_next;
                scan_idx_d = scan_idx_q + 6'd1;
                if (scan_idx_q == 6'd63) begin
                    p1_count_d = acc1_next;
                    p2_count_d = acc2_next;
                    // turn already toggled at COMMIT, so turn_q names the opponent of the mover.
                    if (!reset_scan_q && ((turn_q ? acc2_next : acc1_next) == 5'd0)) begin
                        game_over_d = 1'b1;
                        winner_d    = ~turn_q;
                    end
                    state_d = reset_scan_q ? S_IDLE : S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (new_game) begin
            state_d      = S_SCAN;
            board_d      = INIT_BOARD;
            turn_d       = FIRST_PLAYER;
            game_over_d  = 1'b0;
            winner_d     = 1'b0;
            p1_count_d   = 5'd0;
            p2_count_d   = 5'd0;
            code_d       = OK_MOVE;
            scan_idx_d   = 6'd0;
            acc1_d       = 5'd0;
            acc2_d       = 5'd0;
            reset_scan_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SCAN;
            board_q      <= INIT_BOARD;
            turn_q       <= FIRST_PLAYER;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
            p1_count_q   <= 5'd0;
            p2_count_q   <= 5'd0;
            fx_q         <= 4'd0;
            fy_q         <= 4'd0;
            tx_q         <= 4'd0;
            ty_q         <= 4'd0;
            src_q        <= 3'd0;
            dst_q        <= 3'd0;
            mid_q        <= 3'd0;
            code_q       <= OK_MOVE;
            scan_idx_q   <= 6'd0;
            acc1_q       <= 5'd0;
            acc2_q       <= 5'd0;
            reset_scan_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            p1_count_q   <= p1_count_d;
            p2_count_q   <= p2_count_d;
            fx_q         <= fx_d;
            fy_q         <= fy_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            mid_q        <= mid_d;
            code_q       <= code_d;
            scan_idx_q   <= scan_idx_d;
            acc1_q       <= acc1_d;
            acc2_q       <= acc2_d;
            reset_scan_q <= reset_scan_d;
        end
    end

    assign move_ready   = (state_q == S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign result_code  = code_q;
    assign board_out    = board_q;
    assign turn         = turn_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign p1_count     = p1_count_q;
    assign p2_count     = p2_count_q;

endmodule

// File: tb/tb_checkers_move_engine.sv
// Directed bench for checkers_move_engine: standard-opening instance plus a two-piece
// endgame instance for promotion and game over.
module tb_checkers_move_engine;

    localparam logic [191:0] INIT_STD = 192'o02020202_20202020_02020202_70707070_07070707_10101010_01010101_10101010;
    localparam logic [191:0] INIT_END = 192'o07070707_70207070_07010707_70707070_07070707_70707070_07070707_70707070;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         new_game_a = 1'b0, new_game_b = 1'b0;
    logic         mv_a = 1'b0, mv_b = 1'b0;
    logic [3:0]   fx = 4'd0, fy = 4'd0, tx = 4'd0, ty = 4'd0;

    logic         ready_a, rv_a, turn_a, go_a, win_a;
    logic [2:0]   code_a;
    logic [191:0] board_a;
    logic [4:0]   p1_a, p2_a;
    logic         ready_b, rv_b, turn_b, go_b, win_b;
    logic [2:0]   code_b;
    logic [191:0] board_b;
    logic [4:0]   p1_b, p2_b;

    int           n_vec = 0;
    int           n_bad = 0;
    logic [191:0] exp_a;

    always #5 clk = ~clk;

    checkers_move_engine u_dut_a (
        .clk(clk), .rst(rst), .new_game(new_game_a), .move_valid(mv_a), .move_ready(ready_a),
        .from_x(fx), .from_y(fy), .to_x(tx), .to_y(ty),
        .result_valid(rv_a), .result_code(code_a), .board_out(board_a), .turn(turn_a),
        .game_over(go_a), .winner(win_a), .p1_count(p1_a), .p2_count(p2_a)
    );

    checkers_move_engine #(.INIT_BOARD(INIT_END), .FIRST_PLAYER(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .new_game(new_game_b), .move_valid(mv_b), .move_ready(ready_b),
        .from_x(fx), .from_y(fy), .to_x(tx), .to_y(ty),
        .result_valid(rv_b), .result_code(code_b), .board_out(board_b), .turn(turn_b),
        .game_over(go_b), .winner(win_b), .p1_count(p1_b), .p2_count(p2_b)
    );

    function automatic logic [191:0] with_cell(input logic [191:0] b, input int x, input int y,
                                               input logic [2:0] v);
        logic [191:0] r;
        int base;
        r = b;
        base = 191 - 3 * ((y - 1) * 8 + (x - 1));
        for (int i = 0; i < 3; i++) r[base - i] = v[2 - i];
        return r;
    endfunction

    task automatic do_move(input bit sel, input int x0, input int y0, input int x1, input int y1,
                           output logic [2:0] code, output int cyc);
        bit rdy;
        rdy  = 1'b0;
        cyc  = -2;
        code = 3'd7;
        for (int i = 0; i < 300 && !rdy; i++) begin
            @(negedge clk);
            rdy = sel ? ready_b : ready_a;
        end
        if (!rdy) return;
        fx = 4'(x0); fy = 4'(y0); tx = 4'(x1); ty = 4'(y1);
        if (sel) mv_b = 1'b1; else mv_a = 1'b1;
        @(posedge clk);
        #1;
        mv_a = 1'b0; mv_b = 1'b0;
        fx = 4'd0; fy = 4'd0; tx = 4'd0; ty = 4'd0;
        cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (sel ? rv_b : rv_a) begin
                cyc  = k + 1;
                code = sel ? code_b : code_a;
                break;
            end
        end
    endtask

    task automatic wait_idle_a(output int edges, output bit saw_rv);
        edges  = -1;
        saw_rv = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (rv_a) saw_rv = 1'b1;
            if (ready_a) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic pulse_new_game_a();
        int  e;
        bit  s;
        @(negedge clk);
        new_game_a = 1'b1;
        @(posedge clk);
        #1;
        new_game_a = 1'b0;
        wait_idle_a(e, s);
    endtask

    task automatic test_reset();
        int edges;
        bit saw;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (board_a !== INIT_STD) begin n_bad++; $display("[TB] FAIL reset_board got %h want %h", board_a, INIT_STD); end
        n_vec++; if ({turn_a, go_a, win_a, rv_a, code_a} !== 7'b0) begin n_bad++; $display("[TB] FAIL reset_flags got turn/go/win/rv/code=%b want 0000000", {turn_a, go_a, win_a, rv_a, code_a}); end
        n_vec++; if (ready_a !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready_during_scan got %b want 0", ready_a); end
        @(negedge clk);
        rst = 1'b0;
        wait_idle_a(edges, saw);
        n_vec++; if (edges !== 64) begin n_bad++; $display("[TB] FAIL reset_scan_len got %0d want 64", edges); end
        n_vec++; if (saw !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_no_result got %b want 0", saw); end
        n_vec++; if ({p1_a, p2_a} !== {5'd12, 5'd12}) begin n_bad++; $display("[TB] FAIL reset_counts got %0d/%0d want 12/12", p1_a, p2_a); end
        n_vec++; if ({ready_a, ready_b, p1_b, p2_b} !== {2'b11, 5'd1, 5'd1}) begin n_bad++; $display("[TB] FAIL reset_endgame got rdy=%b%b %0d/%0d want 11 1/1", ready_a, ready_b, p1_b, p2_b); end
        n_vec++; if (board_b !== INIT_END) begin n_bad++; $display("[TB] FAIL reset_board_b got %h want %h", board_b, INIT_END); end
        exp_a = INIT_STD;
    endtask

    task automatic test_step();
        logic [2:0] code;
        int cyc;
        do_move(0, 1, 6, 2, 5, code, cyc);
        exp_a = with_cell(with_cell(exp_a, 1, 6, 3'b111), 2, 5, 3'b001);
        n_vec++; if (cyc !== 68) begin n_bad++; $display("[TB] FAIL step_latency got %0d want 68", cyc); end
        n_vec++; if (code !== 3'd0) begin n_bad++; $display("[TB] FAIL step_code got %0d want 0", code); end
        n_vec++; if (board_a !== exp_a) begin n_bad++; $display("[TB] FAIL step_board got %h want %h", board_a, exp_a); end
        n_vec++; if ({turn_a, p1_a, p2_a} !== {1'b1, 5'd12, 5'd12}) begin n_bad++; $display("[TB] FAIL step_turn_counts got %b %0d/%0d want 1 12/12", turn_a, p1_a, p2_a); end
        @(posedge clk);
        #1;
        n_vec++; if ({rv_a, ready_a} !== 2'b01) begin n_bad++; $display("[TB] FAIL step_pulse got rv/ready=%b%b want 01", rv_a, ready_a); end
    endtask

    task automatic test_capture();
        logic [2:0] code;
        int cyc;
        do_move(0, 4, 3, 3, 4, code, cyc);
        exp_a = with_cell(with_cell(exp_a, 4, 3, 3'b111), 3, 4, 3'b010);
        n_vec++; if ({cyc, code} !== {32'd68, 3'd0}) begin n_bad++; $display("[TB] FAIL p2_step got cyc %0d code %0d want 68 0", cyc, code); end
        n_vec++; if ({board_a, turn_a} !== {exp_a, 1'b0}) begin n_bad++; $display("[TB] FAIL p2_step_board got %h t%b want %h t0", board_a, turn_a, exp_a); end
        do_move(0, 2, 5, 4, 3, code, cyc);
        exp_a = with_cell(with_cell(with_cell(exp_a, 2, 5, 3'b111), 3, 4, 3'b111), 4, 3, 3'b001);
        n_vec++; if ({cyc, code} !== {32'd68, 3'd1}) begin n_bad++; $display("[TB] FAIL capture_code got cyc %0d code %0d want 68 1", cyc, code); end
        n_vec++; if (board_a !== exp_a) begin n_bad++; $display("[TB] FAIL capture_board got %h want %h", board_a, exp_a); end
        n_vec++; if ({p1_a, p2_a, turn_a, go_a} !== {5'd12, 5'd11, 1'b1, 1'b0}) begin n_bad++; $display("[TB] FAIL capture_counts got %0d/%0d t%b go%b want 12/11 t1 go0", p1_a, p2_a, turn_a, go_a); end
    endtask

    task automatic test_errors();
        logic [2:0] code;
        int cyc;
        pulse_new_game_a();
        do_move(0, 1, 6, 1, 5, code, cyc);
        n_vec++; if ({cyc, code} !== {32'd3, 3'd4}) begin n_bad++; $display("[TB] FAIL err_dst got cyc %0d code %0d want 3 4", cyc, code); end
        do_move(0, 2, 3, 3, 4, code, cyc);
        n_vec++; if ({cyc, code} !== {32'd3, 3'd3}) begin n_bad++; $display("[TB] FAIL err_src got cyc %0d code %0d want 3 3", cyc, code); end
        do_move(0, 0, 6, 1, 5, code, cyc);
        n_vec++; if ({cyc, code} !== {32'd3, 3'd2}) begin n_bad++; $display("[TB] FAIL err_range_zero got cyc %0d code %0d want 3 2", cyc, code); end
        do_move(0, 1, 6, 9, 5, code, cyc);
        n_vec++; if (code !== 3'd2) begin n_bad++; $display("[TB] FAIL err_range_nine got %0d want 2", code); end
        n_vec++; if ({board_a, turn_a, p1_a, p2_a} !== {INIT_STD, 1'b0, 5'd12, 5'd12}) begin n_bad++; $display("[TB] FAIL err_unchanged got %h t%b %0d/%0d", board_a, turn_a, p1_a, p2_a); end
    endtask

    task automatic test_geom();
        logic [2:0] code;
        int cyc;
        pulse_new_game_a();
        do_move(0, 1, 6, 2, 5, code, cyc);
        do_move(0, 4, 3, 3, 4, code, cyc);
        exp_a = with_cell(with_cell(INIT_STD, 1, 6, 3'b111), 2, 5, 3'b001);
        exp_a = with_cell(with_cell(exp_a, 4, 3, 3'b111), 3, 4, 3'b010);
        do_move(0, 2, 5, 1, 6, code, cyc);
        n_vec++; if ({cyc, code} !== {32'd3, 3'd5}) begin n_bad++; $display("[TB] FAIL geom_backward got cyc %0d code %0d want 3 5", cyc, code); end
        do_move(0, 7, 6, 5, 4, code, cyc);
        n_vec++; if (code !== 3'd5) begin n_bad++; $display("[TB] FAIL geom_empty_jump got %0d want 5", code); end
        n_vec++; if ({board_a, turn_a} !== {exp_a, 1'b0}) begin n_bad++; $display("[TB] FAIL geom_unchanged got %h t%b want %h t0", board_a, turn_a, exp_a); end
    endtask

    task automatic test_promotion_game_over();
        logic [2:0]   code;
        int           cyc;
        logic [191:0] exp_b;
        exp_b = with_cell(with_cell(with_cell(INIT_END, 4, 3, 3'b111), 3, 2, 3'b111), 2, 1, 3'b011);
        do_move(1, 4, 3, 2, 1, code, cyc);
        n_vec++; if ({cyc, code} !== {32'd68, 3'd1}) begin n_bad++; $display("[TB] FAIL promo_code got cyc %0d code %0d want 68 1", cyc, code); end
        n_vec++; if (board_b !== exp_b) begin n_bad++; $display("[TB] FAIL promo_board got %h want %h", board_b, exp_b); end
        n_vec++; if ({go_b, win_b, p1_b, p2_b, turn_b} !== {1'b1, 1'b0, 5'd1, 5'd0, 1'b1}) begin n_bad++; $display("[TB] FAIL game_over got go%b win%b %0d/%0d t%b want go1 win0 1/0 t1", go_b, win_b, p1_b, p2_b, turn_b); end
        do_move(1, 0, 1, 2, 2, code, cyc);
        n_vec++; if ({cyc, code} !== {32'd3, 3'd6}) begin n_bad++; $display("[TB] FAIL err_over got cyc %0d code %0d want 3 6", cyc, code); end
        n_vec++; if ({board_b, go_b} !== {exp_b, 1'b1}) begin n_bad++; $display("[TB] FAIL over_sticky got %h go%b", board_b, go_b); end
    endtask

    task automatic test_new_game_abort();
        int edges;
        bit saw;
        pulse_new_game_a();
        @(negedge clk);
        fx = 4'd1; fy = 4'd6; tx = 4'd2; ty = 4'd5;
        mv_a = 1'b1;
        @(posedge clk);
        #1;
        mv_a = 1'b0;
        saw = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            @(posedge clk);
            #1;
            if (rv_a) saw = 1'b1;
        end
        @(negedge clk);
        new_game_a = 1'b1;
        @(posedge clk);
        #1;
        new_game_a = 1'b0;
        n_vec++; if ({board_a, ready_a, turn_a} !== {INIT_STD, 1'b0, 1'b0}) begin n_bad++; $display("[TB] FAIL abort_reload got %h rdy%b t%b", board_a, ready_a, turn_a); end
        wait_idle_a(edges, saw);
        n_vec++; if (edges !== 64) begin n_bad++; $display("[TB] FAIL abort_rescan got %0d want 64", edges); end
        n_vec++; if (saw !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_no_result got %b want 0", saw); end
        n_vec++; if ({board_a, p1_a, p2_a} !== {INIT_STD, 5'd12, 5'd12}) begin n_bad++; $display("[TB] FAIL abort_state got %h %0d/%0d", board_a, p1_a, p2_a); end
    endtask

    task automatic test_back_to_back();
        int         edges;
        bit         saw;
        logic [2:0] code;
        int         cyc;
        @(negedge clk);
        fx = 4'd1; fy = 4'd6; tx = 4'd2; ty = 4'd5;
        mv_a = 1'b1;
        new_game_a = 1'b1;
        @(posedge clk);
        #1;
        mv_a = 1'b0;
        new_game_a = 1'b0;
        wait_idle_a(edges, saw);
        n_vec++; if ({edges, saw} !== {32'd64, 1'b0}) begin n_bad++; $display("[TB] FAIL newgame_priority got edges %0d rv %b want 64 0", edges, saw); end
        n_vec++; if ({board_a, turn_a} !== {INIT_STD, 1'b0}) begin n_bad++; $display("[TB] FAIL newgame_priority_board got %h t%b", board_a, turn_a); end
        do_move(0, 3, 6, 4, 5, code, cyc);
        do_move(0, 6, 3, 5, 4, code, cyc);
        exp_a = with_cell(with_cell(INIT_STD, 3, 6, 3'b111), 4, 5, 3'b001);
        exp_a = with_cell(with_cell(exp_a, 6, 3, 3'b111), 5, 4, 3'b010);
        n_vec++; if ({cyc, code, board_a, turn_a} !== {32'd68, 3'd0, exp_a, 1'b0}) begin n_bad++; $display("[TB] FAIL b2b got cyc %0d code %0d %h t%b", cyc, code, board_a, turn_a); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_step();
        test_capture();
        test_errors();
        test_geom();
        test_promotion_game_over();
        test_new_game_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
